// File: rtl/pht_ctrl_pkg.sv
// Shared definitions for the PHT controller: counter encodings, controller
// states and the 2-bit saturating-counter update rule.
package pht_ctrl_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PRED_RESP,
        UPD_MOD,
        UPD_WR
    } state_t;

    // Saturating step: taken moves toward ST, not-taken toward SNT.
    function automatic logic [1:0] sat_upd(input logic [1:0] cnt, input logic torn);
        logic [1:0] nxt;
        nxt = cnt;
        if (torn) begin
            case (cnt)
                SNT:     nxt = WNT;
                WNT:     nxt = WT;
                default: nxt = ST;
            endcase
        end else begin
            case (cnt)
                ST:      nxt = WT;
                WT:      nxt = WNT;
                default: nxt = SNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// QDEPTH-deep FIFO of pending counter updates {idx, torn}.
module pht_upd_fifo #(
    parameter int IDX_W  = 4,
    parameter int QDEPTH = 2,
    localparam int CW    = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             push_torn,
    input  logic             pop,
    output logic [IDX_W-1:0] head_idx,
    output logic             head_torn,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [IDX_W-1:0] idx_mem  [QDEPTH];
    logic             torn_mem [QDEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(QDEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_idx  = idx_mem[rd_ptr];
    assign head_torn = torn_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            idx_mem[wr_ptr]  <= push_idx;
            torn_mem[wr_ptr] <= push_torn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pht_ctrl.sv
// Arbitrates one single-port PHT between prediction lookups and queued
// saturating-counter updates; sweeps the table to weakly-not-taken after reset.
module pht_ctrl
    import pht_ctrl_pkg::*;
#(
    parameter int IDX_W  = 4,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_req,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_ack,
    output logic [1:0]       pred_cnt,
    output logic             pred_taken,
    input  logic             upd_req,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_torn,
    output logic             upd_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_done,
    output logic             busy
);

    localparam int CW = $clog2(QDEPTH + 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [1:0]       upd_val;
    logic [IDX_W-1:0] head_idx;
    logic             head_torn;
    logic [CW-1:0]    count;
    logic             empty, full, take_pred;

    pht_upd_fifo #(.IDX_W(IDX_W), .QDEPTH(QDEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (upd_req && upd_ready),
        .push_idx  (upd_idx),
        .push_torn (upd_torn),
        .pop       (state == UPD_WR),
        .head_idx  (head_idx),
        .head_torn (head_torn),
        .count     (count),
        .empty     (empty)
    );

    // Ready follows the registered count only, so a pop this cycle cannot free a slot.
    assign full       = (count == CW'(QDEPTH));
    assign upd_ready  = init_done && !full;
    assign take_pred  = pred_req && !full;
    assign pred_taken = pred_cnt[1];
    assign busy       = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            ptr       <= '0;
            upd_val   <= SNT;
            pred_ack  <= 1'b0;
            pred_cnt  <= SNT;
            init_done <= 1'b0;
        end else begin
            pred_ack <= 1'b0;
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (take_pred)   state <= PRED_RESP;
                    else if (!empty) state <= UPD_MOD;
                end
                PRED_RESP: begin
                    pred_cnt <= tbl_rdata;
                    pred_ack <= 1'b1;
                    state    <= IDLE;
                end
                UPD_MOD: begin
                    upd_val <= sat_upd(tbl_rdata, head_torn);
                    state   <= UPD_WR;
                end
                UPD_WR:  state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

    // The arbitration read is issued in the IDLE cycle itself so that rdata is
    // back one cycle later; only the IDLE address mux looks at pred_idx.
    always_comb begin
        tbl_en    = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = SNT;
        case (state)
            INIT: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = ptr;
                tbl_wdata = WNT;
            end
            IDLE: begin
                if (take_pred) begin
                    tbl_en   = 1'b1;
                    tbl_addr = pred_idx;
                end else if (!empty) begin
                    tbl_en   = 1'b1;
                    tbl_addr = head_idx;
                end
            end
            UPD_WR: begin
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_addr  = head_idx;
                tbl_wdata = upd_val;
            end
            default: ;
        endcase
    end

endmodule
